ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter for the EG2000 keyboard port: the opposite direction to the existing keyboard scan-code receiver. It sends single command bytes to the keyboard, e.g. 0xED plus the LED mask, or 0xFF for reset. It drives the shared ps2 clock/data lines open-drain, runs the full request-to-send handshake, checks the device acknowledge, and reports done or error. While it owns the lines it asserts `busy`, so the receiver can ignore bus activity.

---
 rtl/eg2000_pkg.sv | 25 ++
 rtl/ps2_line_filter.sv | 43 ++++
 rtl/ps2_host_tx.sv | 139 +++++++++++++
 tb/tb_ps2_host_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/eg2000_pkg.sv
// Shared EG2000 keyboard-port definitions: PS/2 transmitter states and the
// timing constants derived from the 35.468 MHz system clock.
package eg2000_pkg;

    localparam int unsigned CLK_HZ          = 35468000;
    // Rounded up so the clock line is held low for at least 100 us.
    localparam int unsigned PS2_INHIBIT_CYC = (CLK_HZ + 9999) / 10000;
    localparam int unsigned PS2_TIMEOUT_CYC = (CLK_HZ / 1000) * 15;
    localparam int unsigned PS2_FILTER_CYC  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_WAITIDLE,
        S_DONE,
        S_ERR
    } ps2tx_state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus level filter for one PS/2 pin; a new level is
// accepted only after FILTER consecutive samples disagree with the current one.
module ps2_line_filter #(
    parameter int unsigned FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILTER + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != level) && (cnt == CW'(FILTER - 1));

    // Idle PS/2 lines float high, so everything resets to 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            fall  <= accept && level;
            if (sync2 == level || accept)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (accept)
                level <= sync2;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-clock frame
// with device acknowledge, open-drain line control and done/error reporting.
module ps2_host_tx
    import eg2000_pkg::*;
#(
    parameter int unsigned INHIBIT = PS2_INHIBIT_CYC,
    parameter int unsigned TIMEOUT = PS2_TIMEOUT_CYC,
    parameter int unsigned FILTER  = PS2_FILTER_CYC
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   data,
    output logic         busy,
    output logic         done,
    output logic         error,
    input  logic         ps2ClkIn,
    input  logic         ps2DatIn,
    output logic         ps2ClkOe,
    output logic         ps2DatOe,
    output ps2tx_state_t state_dbg
);

    // Handshake: start is a one-cycle request honoured only while busy is low;
    // busy rises the next cycle and falls in the cycle done or error pulses.

    ps2tx_state_t state, next_state;
    logic [19:0]  inh_cnt;
    logic [19:0]  to_cnt;
    logic [3:0]   bit_cnt;
    logic [7:0]   byte_q;
    logic         par_q;
    logic         dat_q;
    logic         clk_level, clk_fall;
    logic         dat_level, dat_fall_unused;
    logic         inh_last, timed_out, line_owned;

    ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
        .clock (clock),
        .reset (reset),
        .pin   (ps2ClkIn),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER(1)) u_dat_filter (
        .clock (clock),
        .reset (reset),
        .pin   (ps2DatIn),
        .level (dat_level),
        .fall  (dat_fall_unused)
    );

    assign inh_last   = (inh_cnt == 20'(INHIBIT - 1));
    assign timed_out  = (to_cnt == 20'(TIMEOUT - 1));
    assign line_owned = (state == S_REQ) || (state == S_SHIFT) || (state == S_WAITIDLE);
    assign state_dbg  = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            inh_cnt <= '0;
            to_cnt  <= '0;
            bit_cnt <= '0;
            byte_q  <= '0;
            par_q   <= 1'b0;
            dat_q   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    inh_cnt <= '0;
                    bit_cnt <= '0;
                    dat_q   <= 1'b0;
                    if (start) begin
                        byte_q <= data;
                        par_q  <= odd_parity(data);
                    end
                end
                S_INHIBIT: begin
                    to_cnt <= '0;
                    if (inh_last)
                        dat_q <= 1'b1;
                    else
                        inh_cnt <= inh_cnt + 20'd1;
                end
                S_REQ: begin
                    bit_cnt <= '0;
                    if (!timed_out) to_cnt <= to_cnt + 20'd1;
                end
                S_SHIFT: begin
                    if (!timed_out) to_cnt <= to_cnt + 20'd1;
                    // bit_cnt holds the falls already seen; this fall is bit_cnt+1.
                    if (clk_fall && bit_cnt != 4'd11) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8)
                            dat_q <= ~byte_q[bit_cnt[2:0]];
                        else if (bit_cnt == 4'd8)
                            dat_q <= ~par_q;
                        else
                            dat_q <= 1'b0;
                    end
                end
                S_WAITIDLE: begin
                    if (!timed_out) to_cnt <= to_cnt + 20'd1;
                end
                default: begin
                    dat_q   <= 1'b0;
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start) next_state = S_INHIBIT;
            S_INHIBIT:  if (inh_last) next_state = S_REQ;
            S_REQ:      next_state = S_SHIFT;
            S_SHIFT:    if (clk_fall && bit_cnt == 4'd10)
                            next_state = dat_level ? S_ERR : S_WAITIDLE;
            S_WAITIDLE: if (clk_level && dat_level) next_state = S_DONE;
            default:    next_state = S_IDLE;
        endcase
        if (line_owned && timed_out)
            next_state = S_ERR;
    end

    always_comb begin
        busy     = (state == S_INHIBIT) || line_owned;
        done     = (state == S_DONE);
        error    = (state == S_ERR);
        ps2ClkOe = (state == S_INHIBIT);
        ps2DatOe = ((state == S_INHIBIT) && inh_last) || (line_owned && dat_q);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a vector table of command bytes driven
// through a wired-AND PS/2 bus with a simple device model.
module tb_ps2_host_tx;
    import eg2000_pkg::*;

    localparam int INH_T = 20;
    localparam int TO_T  = 2000;
    localparam int FLT   = 4;
    localparam int HALF  = 30;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   data  = 8'h00;
    logic         busy, done, error;
    logic         ps2ClkIn, ps2DatIn, ps2ClkOe, ps2DatOe;
    ps2tx_state_t state_dbg;
    logic         dev_clk = 1'b1;
    logic         dev_dat = 1'b1;

    int checks   = 0;
    int failures = 0;
    int done_total = 0;
    int err_total  = 0;
    logic [9:0] exp_q[$];

    // mode: 0 normal, 1 start during frame, 2 clock glitch, 3 device silent, 4 reset mid-frame
    typedef struct {
        logic [7:0] data;
        logic       ack;
        int         mode;
        logic [9:0] exp_frame;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    assign ps2ClkIn = dev_clk & ~ps2ClkOe;
    assign ps2DatIn = dev_dat & ~ps2DatOe;

    ps2_host_tx #(.INHIBIT(INH_T), .TIMEOUT(TO_T), .FILTER(FLT)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .ps2ClkIn  (ps2ClkIn),
        .ps2DatIn  (ps2DatIn),
        .ps2ClkOe  (ps2ClkOe),
        .ps2DatOe  (ps2DatOe),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done)  done_total <= done_total + 1;
        if (error) err_total  <= err_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic dev_frame(input logic ack, input int mode, output logic [9:0] frame);
        frame = '0;
        repeat (5) @(negedge clock);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (mode == 1 && k == 5) begin
                start = 1'b1;
                data  = 8'h55;
                @(negedge clock);
                start = 1'b0;
                repeat (HALF - 1) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            if (mode == 4 && k == 4) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("reset_mid_oe", {30'd0, ps2ClkOe, ps2DatOe}, 32'd0);
                chk("reset_mid_busy", {31'd0, busy}, 32'd0);
                dev_clk = 1'b1;
                repeat (10) @(negedge clock);
                return;
            end
            if (k <= 10) frame[k-1] = ps2DatIn;
            dev_clk = 1'b1;
            if (mode == 2 && k == 3) begin
                repeat (10) @(negedge clock);
                dev_clk = 1'b0;
                repeat (FLT - 1) @(negedge clock);
                dev_clk = 1'b1;
                repeat (HALF - 10 - (FLT - 1)) @(negedge clock);
            end else if (k == 10 && ack) begin
                repeat (5) @(negedge clock);
                dev_dat = 1'b0;
                repeat (HALF - 5) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
        end
        dev_dat = 1'b1;
    endtask

    initial begin
        vec_t       v;
        logic [9:0] frame;
        logic [9:0] exp_frame;
        int         n, k, base_done, base_err;
        logic       last_dat, dat_early;

        vecs[0] = '{8'hED, 1'b1, 0, 10'h3ED, 1, 0};
        vecs[1] = '{8'h07, 1'b1, 1, 10'h207, 1, 0};
        vecs[2] = '{8'h3C, 1'b1, 3, 10'h000, 0, 1};
        vecs[3] = '{8'h5A, 1'b0, 0, 10'h35A, 0, 1};
        vecs[4] = '{8'h96, 1'b1, 4, 10'h000, 0, 0};
        vecs[5] = '{8'hFF, 1'b1, 0, 10'h3FF, 1, 0};
        vecs[6] = '{8'hA5, 1'b1, 2, 10'h3A5, 1, 0};
        vecs[7] = '{8'h01, 1'b1, 0, 10'h201, 1, 0};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        chk("reset_oe", {30'd0, ps2ClkOe, ps2DatOe}, 32'd0);
        chk("reset_state", {29'd0, state_dbg}, {29'd0, S_IDLE});

        for (int i = 0; i < 8; i++) begin
            v         = vecs[i];
            base_done = done_total;
            base_err  = err_total;
            @(negedge clock);
            start = 1'b1;
            data  = v.data;
            @(negedge clock);
            start = 1'b0;
            chk("start_busy", {31'd0, busy}, 32'd1);
            chk("start_clk_oe", {31'd0, ps2ClkOe}, 32'd1);

            n = 0;
            last_dat  = 1'b0;
            dat_early = 1'b0;
            while (ps2ClkOe && n < INH_T + 10) begin
                n++;
                last_dat = ps2DatOe;
                if (ps2DatOe && n < INH_T) dat_early = 1'b1;
                @(negedge clock);
            end
            chk("inhibit_len", n, INH_T);
            chk("inhibit_dat", {30'd0, dat_early, last_dat}, 32'd1);
            chk("request_lines", {30'd0, ps2ClkOe, ps2DatOe}, 32'd1);

            if (v.mode == 3) begin
                k = 0;
                while (!error && k < TO_T + 50) begin
                    @(negedge clock);
                    k++;
                end
                chk("timeout_cycles", k, TO_T);
                chk("timeout_oe", {30'd0, ps2ClkOe, ps2DatOe}, 32'd0);
            end else begin
                if (v.mode != 4) exp_q.push_back(v.exp_frame);
                dev_frame(v.ack, v.mode, frame);
                if (v.mode != 4) begin
                    exp_frame = exp_q.pop_front();
                    chk("frame_bits", {22'd0, frame}, {22'd0, exp_frame});
                end
                k = 0;
                while (busy && k < 300) begin
                    @(negedge clock);
                    k++;
                end
                chk("end_wait_bounded", {31'd0, (k < 300)}, 32'd1);
            end

            repeat (3) @(negedge clock);
            chk("done_pulses", done_total - base_done, v.exp_done);
            chk("error_pulses", err_total - base_err, v.exp_err);
            chk("end_busy", {31'd0, busy}, 32'd0);
            chk("end_oe", {30'd0, ps2ClkOe, ps2DatOe}, 32'd0);
            chk("end_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
